tl_cntr: RTL and testbench
==========================

TL_CNTR -- requirements
Module: tl_cntr

Interface
REQ-001 Parameter YELLOW_CYCLES, default 1, number of clock cycles each yellow phase lasts (legal range 1..255).
REQ-002 The block SHALL have exactly one clock and an asynchronous active-high reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset; forces reset state immediately, independent of clk.
REQ-005 Ta  input  1  traffic sensor, street A; 1 = traffic present on A.
REQ-006 Tb  input  1  traffic sensor, street B; 1 = traffic present on B.
REQ-007 La  output  2  light for street A; encoding GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 never driven.
REQ-008 Lb  output  2  light for street B; same encoding as La.

Function
REQ-009 Four-state Moore FSM: S0 (A green), S1 (A yellow), S2 (B green), S3 (B yellow).
REQ-010 Outputs depend on state only: S0 La=GREEN Lb=RED; S1 La=YELLOW Lb=RED; S2 La=RED Lb=GREEN; S3 La=RED Lb=YELLOW.
REQ-011 S0: Ta=1 -> stay S0; Ta=0 -> S1 at the next rising edge.
REQ-012 S1: stay YELLOW_CYCLES cycles total, then -> S2 unconditionally; Ta/Tb ignored.
REQ-013 S2: Tb=1 -> stay S2; Tb=0 -> S3 at the next rising edge.
REQ-014 S3: stay YELLOW_CYCLES cycles total, then -> S0 unconditionally; Ta/Tb ignored.
REQ-015 Yellow dwell counter: loaded to 0 on entering S1/S3, incremented each cycle in S1/S3, exit when count = YELLOW_CYCLES-1; width sufficient for 255.
REQ-016 Sensors sampled only on rising clk; no latching of prior sensor values.
REQ-017 At no time SHALL La and Lb both be non-RED; outputs glitch-free (registered or decoded from registered state only).
REQ-018 Unreachable state encodings SHALL recover to S0 on the next rising edge.
REQ-019 Ta=Tb=1 simultaneously: current green holds indefinitely (no arbitration).
REQ-020 Ta=Tb=0 simultaneously: FSM cycles S0->S1->S2->S3->S0 continuously.

Reset
REQ-021 reset=1 SHALL force state S0 and yellow counter 0 asynchronously: La=GREEN, Lb=RED within the same time step, no clock needed.
REQ-022 While reset=1, state SHALL remain S0 regardless of clk, Ta, Tb.
REQ-023 Reset asserted mid-yellow or mid-B-green SHALL abort the phase and return to S0 immediately.
REQ-024 After reset deasserts, the first transition evaluation occurs at the next rising clk edge.

Verification
REQ-025 reset pulse 1->0 with Ta=1,Tb=0, no clock edge during pulse -> La=00, Lb=10 immediately.
REQ-026 After reset, Ta=1,Tb=1 for 3 cycles -> La=00, Lb=10 every cycle.
REQ-027 In S0 drive Ta=0 (YELLOW_CYCLES=1) -> edge1: La=01 Lb=10; edge2: La=10 Lb=00; held while Tb=1.
REQ-028 In S2 drive Tb=0, Ta=1 -> edge1: La=10 Lb=01; edge2: La=00 Lb=10; held while Ta=1.
REQ-029 Ta=0,Tb=0 continuously -> repeating 4-cycle sequence (00,10),(01,10),(10,00),(10,01); with YELLOW_CYCLES=3 each yellow lasts exactly 3 cycles.
REQ-030 Assert reset while in S1 or S3 -> La=00, Lb=10 before next clk edge; no cycle ever shows both lights non-RED.

Source files
------------

// File: rtl/tl_cntr.sv
// Purpose : two-street traffic light controller, four-state Moore FSM with a
//           programmable yellow dwell (YELLOW_CYCLES clock cycles per yellow).
// Latency : lights change one clk edge after the sensor condition is sampled;
//           reset acts asynchronously and forces A green / B red immediately.
// Ports   : clk, reset (async active-high), Ta/Tb traffic sensors,
//           La/Lb lights (GREEN=00, YELLOW=01, RED=10; 11 never driven).
module tl_cntr #(
    parameter int YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    typedef enum logic [1:0] {
        S0 = 2'b00,   // A green
        S1 = 2'b01,   // A yellow
        S2 = 2'b10,   // B green
        S3 = 2'b11    // B yellow
    } state_t;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    // Last count value of a yellow phase; the phase exits on this cycle.
    localparam logic [7:0] YEL_LAST = 8'(YELLOW_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. The dwell counter is cleared whenever the FSM is not
    // staying inside a yellow phase, so it always starts at 0 on entry.
    always_comb begin
        state_next = S0;
        cnt_next   = '0;
        case (state)
            S0: state_next = Ta ? S0 : S1;
            S1: begin
                if (cnt == YEL_LAST) begin
                    state_next = S2;
                end else begin
                    state_next = S1;
                    cnt_next   = cnt + 8'd1;
                end
            end
            S2: state_next = Tb ? S2 : S3;
            S3: begin
                if (cnt == YEL_LAST) begin
                    state_next = S0;
                end else begin
                    state_next = S3;
                    cnt_next   = cnt + 8'd1;
                end
            end
            default: state_next = S0;
        endcase
    end

    // Output decode from registered state only, so lights never glitch and
    // at most one street is ever non-red.
    always_comb begin
        La = RED;
        Lb = RED;
        case (state)
            S0: La = GREEN;
            S1: La = YELLOW;
            S2: Lb = GREEN;
            S3: Lb = YELLOW;
            default: begin
                La = RED;
                Lb = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_tl_cntr.sv
module tb_tl_cntr;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    logic       clk;
    logic       reset;
    logic       sa;
    logic       sb;
    logic [1:0] la1, lb1, la3, lb3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0=A green, 1=A yellow, 2=B green, 3=B yellow;
    // left = yellow cycles still to spend in the current yellow phase.
    int mph[2];
    int mleft[2];
    int yc[2] = '{1, 3};

    tl_cntr dut1 (
        .clk   (clk),
        .reset (reset),
        .Ta    (sa),
        .Tb    (sb),
        .La    (la1),
        .Lb    (lb1)
    );

    tl_cntr #(.YELLOW_CYCLES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .Ta    (sa),
        .Tb    (sb),
        .La    (la3),
        .Lb    (lb3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] m_la(input int ph);
        if (ph == 0) return GREEN;
        if (ph == 1) return YELLOW;
        return RED;
    endfunction

    function automatic logic [1:0] m_lb(input int ph);
        if (ph == 2) return GREEN;
        if (ph == 3) return YELLOW;
        return RED;
    endfunction

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at time %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mph[i]   = 0;
            mleft[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            case (mph[i])
                0: if (!sa) begin mph[i] = 1; mleft[i] = yc[i]; end
                1: begin mleft[i]--; if (mleft[i] == 0) mph[i] = 2; end
                2: if (!sb) begin mph[i] = 3; mleft[i] = yc[i]; end
                default: begin mleft[i]--; if (mleft[i] == 0) mph[i] = 0; end
            endcase
        end
    endtask

    // Both instances against the model, plus the never-both-non-red rule.
    task automatic chk_model(input string tag);
        chk({tag, " la1"}, la1, m_la(mph[0]));
        chk({tag, " lb1"}, lb1, m_lb(mph[0]));
        chk({tag, " la3"}, la3, m_la(mph[1]));
        chk({tag, " lb3"}, lb3, m_lb(mph[1]));
        chk({tag, " safe1"}, {1'b0, (la1 != RED) && (lb1 != RED)}, 2'b00);
        chk({tag, " safe3"}, {1'b0, (la3 != RED) && (lb3 != RED)}, 2'b00);
    endtask

    // One rising edge: advance the model with the sensors seen at that edge,
    // then sample the DUTs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset_pulse(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        chk({tag, " rst la1"}, la1, GREEN);
        chk({tag, " rst lb1"}, lb1, RED);
        chk({tag, " rst la3"}, la3, GREEN);
        chk({tag, " rst lb3"}, lb3, RED);
        reset = 1'b0;
        #1;
        chk_model({tag, " post"});
    endtask

    typedef struct {
        logic       ta;
        logic       tb;
        logic [1:0] la;
        logic [1:0] lb;
    } vec_t;

    initial begin
        vec_t vecs[14];
        logic [1:0] y3_la[8];
        logic [1:0] y3_lb[8];

        vecs[0]  = '{1'b1, 1'b1, GREEN,  RED};
        vecs[1]  = '{1'b1, 1'b1, GREEN,  RED};
        vecs[2]  = '{1'b1, 1'b1, GREEN,  RED};
        vecs[3]  = '{1'b0, 1'b1, YELLOW, RED};
        vecs[4]  = '{1'b0, 1'b1, RED,    GREEN};
        vecs[5]  = '{1'b0, 1'b1, RED,    GREEN};
        vecs[6]  = '{1'b1, 1'b0, RED,    YELLOW};
        vecs[7]  = '{1'b1, 1'b0, GREEN,  RED};
        vecs[8]  = '{1'b1, 1'b0, GREEN,  RED};
        vecs[9]  = '{1'b0, 1'b0, YELLOW, RED};
        vecs[10] = '{1'b0, 1'b0, RED,    GREEN};
        vecs[11] = '{1'b0, 1'b0, RED,    YELLOW};
        vecs[12] = '{1'b0, 1'b0, GREEN,  RED};
        vecs[13] = '{1'b0, 1'b0, YELLOW, RED};

        y3_la = '{YELLOW, YELLOW, YELLOW, RED,   RED,    RED,    RED,    GREEN};
        y3_lb = '{RED,    RED,    RED,    GREEN, YELLOW, YELLOW, YELLOW, RED};

        // Reset state with no clock dependence.
        reset = 1'b1;
        sa    = 1'b0;
        sb    = 1'b0;
        model_reset();
        #2;
        chk("reset la1", la1, GREEN);
        chk("reset lb1", lb1, RED);
        chk("reset la3", la3, GREEN);
        chk("reset lb3", lb3, RED);
        #10;
        reset = 1'b0;

        // Short reset pulse between edges with Ta=1, Tb=0.
        @(negedge clk);
        sa = 1'b1;
        sb = 1'b0;
        #1;
        async_reset_pulse("pulse");

        // Table-driven sequence on the YELLOW_CYCLES=1 instance.
        for (int i = 0; i < 14; i++) begin
            sa = vecs[i].ta;
            sb = vecs[i].tb;
            step();
            chk($sformatf("vec%0d la", i), la1, vecs[i].la);
            chk($sformatf("vec%0d lb", i), lb1, vecs[i].lb);
            chk_model($sformatf("vec%0d", i));
        end

        // YELLOW_CYCLES=3: each yellow lasts exactly three cycles.
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("y3 c%0d la", i), la3, y3_la[i]);
            chk($sformatf("y3 c%0d lb", i), lb3, y3_lb[i]);
        end

        // Reset in the middle of A yellow (dut3), and in B yellow.
        step();
        chk("midA pre la3", la3, YELLOW);
        async_reset_pulse("midA");
        sa = 1'b0;
        sb = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midB pre lb3", lb3, YELLOW);
        async_reset_pulse("midB");

        // Randomized stimulus with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            sa = ($urandom_range(0, 3) != 0);
            sb = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                sa = 1'b0;
                sb = 1'b0;
            end
            step();
            chk_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 49) == 0) async_reset_pulse($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
